music_sequencer: RTL and testbench

//   Top-level playback controller for the note-code/divider datapath. Generates the 4-bit mode

---
 rtl/music_sequencer.sv | 138 +++++++++++++
 tb/tb_music_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/music_sequencer.sv
// Playback controller: mode word, score-ROM address and beat pacing.
// Song select, play/pause, stop, keyboard mode and end-of-song handling.
module music_sequencer #(
  parameter int unsigned BEAT_DIV = 3000,
  parameter int unsigned OFS_W    = 8,
  parameter bit          LOOP     = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [1:0]       SONG,
  input  logic             PLAY_PAUSE,
  input  logic             STOP,
  input  logic             KEY_MODE,
  output logic [3:0]       STATE,
  output logic [OFS_W+1:0] ROM_ADDR,
  output logic             BEAT,
  output logic             PLAYING
);

  localparam int PW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(BEAT_DIV - 1);
  localparam logic [OFS_W-1:0] OMAX = '1;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0000,
    S_PLAY  = 4'b0001,
    S_PAUSE = 4'b0010,
    S_KEYB  = 4'b0011,
    S_DONE  = 4'b0100
  } state_t;

  state_t           r_state;
  logic [1:0]       r_song;
  logic [OFS_W-1:0] r_ofs;
  logic [PW-1:0]    r_pre;
  logic             r_beat;
  logic             r_playing;

  state_t           w_state_n;
  logic [1:0]       w_song_n;
  logic [OFS_W-1:0] w_ofs_n;
  logic [PW-1:0]    w_pre_n;
  logic             w_beat_n;
  logic             w_tick;

  assign w_tick = (r_pre == PMAX);

  // State register and all registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_song    <= '0;
      r_ofs     <= '0;
      r_pre     <= '0;
      r_beat    <= 1'b0;
      r_playing <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_song    <= w_song_n;
      r_ofs     <= w_ofs_n;
      r_pre     <= w_pre_n;
      r_beat    <= w_beat_n;
      r_playing <= (w_state_n == S_PLAY);
    end
  end

  // Next state: STOP beats KEY_MODE beats PLAY_PAUSE; losers are dropped.
  always_comb begin
    w_state_n = r_state;
    w_song_n  = r_song;
    w_ofs_n   = r_ofs;
    w_pre_n   = r_pre;
    w_beat_n  = 1'b0;
    if (STOP) begin
      w_state_n = S_IDLE;
      w_ofs_n   = '0;
      w_pre_n   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (KEY_MODE) begin
            w_state_n = S_KEYB;
          end else if (PLAY_PAUSE) begin
            w_state_n = S_PLAY;
            w_song_n  = SONG;
            w_ofs_n   = '0;
            w_pre_n   = '0;
          end
        end
        S_PLAY: begin
          if (PLAY_PAUSE) begin
            w_state_n = S_PAUSE;
          end else if (w_tick) begin
            w_pre_n  = '0;
            w_beat_n = 1'b1;
            if (r_ofs == OMAX) begin
              if (LOOP) w_ofs_n = '0;
              else      w_state_n = S_DONE;
            end else begin
              w_ofs_n = r_ofs + OFS_W'(1);
            end
          end else begin
            w_pre_n = r_pre + PW'(1);
          end
        end
        S_PAUSE: begin
          if (PLAY_PAUSE) w_state_n = S_PLAY;
        end
        S_KEYB: begin
          w_pre_n = '0;
          if (KEY_MODE) begin
            w_state_n = S_IDLE;
            w_ofs_n   = '0;
          end
        end
        S_DONE: begin
          if (KEY_MODE) begin
            w_state_n = S_KEYB;
          end else if (PLAY_PAUSE) begin
            w_state_n = S_PLAY;
            w_song_n  = SONG;
            w_ofs_n   = '0;
            w_pre_n   = '0;
          end
        end
        default: begin
          w_state_n = S_IDLE;
        end
      endcase
    end
  end

  assign STATE    = r_state;
  assign ROM_ADDR = {r_song, r_ofs};
  assign BEAT     = r_beat;
  assign PLAYING  = r_playing;

endmodule

// File: tb/tb_music_sequencer.sv
// Scoreboard bench for music_sequencer, LOOP=0 and LOOP=1 side by side.
// Reference model tracks mode, note index and elapsed play cycles.
module tb_music_sequencer;

  localparam int BD = 4;
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_KEYB = 3, M_DONE = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [1:0] SONG = 2'd0;
  logic       PP = 1'b0, ST = 1'b0, KM = 1'b0;

  logic [3:0] st0, st1;
  logic [4:0] ad0, ad1;
  logic       bt0, bt1, pl0, pl1;

  music_sequencer #(.BEAT_DIV(BD), .OFS_W(3), .LOOP(1'b0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .SONG(SONG), .PLAY_PAUSE(PP),
    .STOP(ST), .KEY_MODE(KM), .STATE(st0), .ROM_ADDR(ad0),
    .BEAT(bt0), .PLAYING(pl0));

  music_sequencer #(.BEAT_DIV(BD), .OFS_W(3), .LOOP(1'b1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .SONG(SONG), .PLAY_PAUSE(PP),
    .STOP(ST), .KEY_MODE(KM), .STATE(st1), .ROM_ADDR(ad1),
    .BEAT(bt1), .PLAYING(pl1));

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] st;
    logic [4:0] ad;
    logic       bt;
    logic       pl;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_chk = 0;
  int n_fail = 0;

  int m_mode[2], m_song[2], m_note[2], m_el[2];

  task automatic chk(input string nm, input exp_t act, input exp_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got st=%b ad=%b bt=%b pl=%b want st=%b ad=%b bt=%b pl=%b",
               nm, $time, act.st, act.ad, act.bt, act.pl,
               exp.st, exp.ad, exp.bt, exp.pl);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_mode[l] = M_IDLE; m_song[l] = 0; m_note[l] = 0; m_el[l] = 0;
    end
  endtask

  // Advance the reference by one clock using the inputs held at that edge.
  task automatic model_step(input logic pp, input logic sp, input logic km,
                            input logic [1:0] sg);
    exp_t e;
    for (int l = 0; l < 2; l++) begin
      logic b;
      b = 1'b0;
      if (sp) begin
        m_mode[l] = M_IDLE; m_note[l] = 0; m_el[l] = 0;
      end else begin
        case (m_mode[l])
          M_IDLE, M_DONE: begin
            if (km) m_mode[l] = M_KEYB;
            else if (pp) begin
              m_mode[l] = M_PLAY; m_song[l] = sg; m_note[l] = 0; m_el[l] = 0;
            end
          end
          M_PLAY: begin
            if (pp) m_mode[l] = M_PAUSE;
            else begin
              m_el[l]++;
              if (m_el[l] == BD) begin
                m_el[l] = 0;
                b = 1'b1;
                if (m_note[l] == 7) begin
                  if (l == 1) m_note[l] = 0;
                  else m_mode[l] = M_DONE;
                end else m_note[l]++;
              end
            end
          end
          M_PAUSE: if (pp) m_mode[l] = M_PLAY;
          M_KEYB: if (km) begin m_mode[l] = M_IDLE; m_note[l] = 0; end
          default: m_mode[l] = M_IDLE;
        endcase
      end
      e.st = 4'(m_mode[l]);
      e.ad = 5'(m_song[l] * 8 + m_note[l]);
      e.bt = b;
      e.pl = (m_mode[l] == M_PLAY);
      if (l == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic cyc(input logic pp, input logic sp, input logic km,
                     input logic [1:0] sg);
    PP = pp; ST = sp; KM = km; SONG = sg;
    @(posedge CLK);
    model_step(pp, sp, km, sg);
    #1;
    PP = 1'b0; ST = 1'b0; KM = 1'b0;
  endtask

  task automatic idle(input int n, input logic [1:0] sg);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, sg);
  endtask

  // Monitor: every cycle the DUTs present a new registered word.
  always @(negedge CLK) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("dut0", {st0, ad0, bt0, pl0}, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("dut1", {st1, ad1, bt1, pl1}, e);
    end
  end

  initial begin
    exp_t z;
    z = '0;
    model_reset();
    #1;
    chk("reset0", {st0, ad0, bt0, pl0}, z);
    chk("reset1", {st1, ad1, bt1, pl1}, z);
    #12 RST_N = 1'b1;
    @(posedge CLK); #1;

    // Song 2 to the end (dut0 -> DONE, dut1 loops).
    cyc(1'b1, 1'b0, 1'b0, 2'd2);
    idle(8 * BD + 3, 2'd1);
    // Pause at prescaler 2 for 10 cycles, then resume.
    cyc(1'b0, 1'b1, 1'b0, 2'd0);
    cyc(1'b1, 1'b0, 1'b0, 2'd1);
    idle(2, 2'd3);
    cyc(1'b1, 1'b0, 1'b0, 2'd3);
    idle(10, 2'd0);
    cyc(1'b1, 1'b0, 1'b0, 2'd2);
    idle(6, 2'd0);
    // Keyboard mode round trip with ignored PLAY_PAUSE.
    cyc(1'b0, 1'b1, 1'b0, 2'd0);
    cyc(1'b0, 1'b0, 1'b1, 2'd0);
    idle(3, 2'd0);
    cyc(1'b1, 1'b0, 1'b0, 2'd0);
    idle(3, 2'd0);
    cyc(1'b0, 1'b0, 1'b1, 2'd0);
    // Priority collisions.
    cyc(1'b1, 1'b0, 1'b0, 2'd3);
    cyc(1'b1, 1'b0, 1'b0, 2'd3);
    cyc(1'b1, 1'b1, 1'b0, 2'd1);
    cyc(1'b1, 1'b0, 1'b1, 2'd1);
    idle(2, 2'd1);
    cyc(1'b0, 1'b0, 1'b1, 2'd1);

    // Async reset mid-play at offset 5.
    cyc(1'b1, 1'b0, 1'b0, 2'd2);
    idle(5 * BD + 1, 2'd0);
    @(negedge CLK); #1;
    RST_N = 1'b0;
    #1;
    chk("arst0", {st0, ad0, bt0, pl0}, z);
    chk("arst1", {st1, ad1, bt1, pl1}, z);
    model_reset();
    @(negedge CLK); #2;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Randomised pulses with SONG churning every cycle.
    for (int i = 0; i < 4000; i++) begin
      logic pp, sp, km;
      pp = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 59) == 0);
      km = ($urandom_range(0, 29) == 0);
      cyc(pp, sp, km, 2'($urandom));
    end

    idle(2, 2'd0);
    @(negedge CLK); #1;
    n_chk++;
    if (q0.size() + q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", q0.size() + q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
